// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module : pll_seq_pkg
// Brief  : State encodings and sizing helper for the PLL reset sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

  localparam int c_STATE_W = 3;

  typedef enum logic [c_STATE_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer with asynchronous active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module : pll_reset_sequencer
// Brief  : Pulses PLL reset, qualifies lock, releases domain resets staggered.
//          Optional timeout/retry/FAIL behaviour under `PLLSEQ_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int NUM_DOMAINS        = 3,
  parameter int STAGGER_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES     = 500000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_pll_lock,
  input  logic                   i_restart,
  output logic                   o_pll_reset,
  output logic [NUM_DOMAINS-1:0] o_domain_rst_n,
  output logic                   o_ready,
  output logic                   o_lock_lost,
  output logic                   o_fail,
  output logic [2:0]             o_state
);

  localparam int unsigned c_REL_LAST = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
`ifdef PLLSEQ_TIMEOUT_EN
  localparam int unsigned c_TO_TERM = TIMEOUT_CYCLES - 1;
  localparam int c_RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
`else
  localparam int unsigned c_TO_TERM = 0;
`endif
  localparam int unsigned c_CNT_MAX = max_u(max_u(RST_HOLD_CYCLES - 1, LOCK_STABLE_CYCLES - 1),
                                            max_u(c_REL_LAST, c_TO_TERM));
  localparam int c_CNT_W = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_RELEASE_END = c_CNT_W'(c_REL_LAST);

  logic                   w_lock_s;
  pll_state_t             r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_pll_reset;
  logic [NUM_DOMAINS-1:0] r_dom;
  logic                   r_ready;
  logic                   r_lock_lost;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_pll_lock),
    .o_q   (w_lock_s)
  );

`ifdef PLLSEQ_TIMEOUT_EN
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(c_TO_TERM);
  logic               r_fail;
  logic [c_RTY_W-1:0] r_retry;
  logic [c_RTY_W-1:0] w_retry_nxt;
  assign w_retry_nxt = r_retry + 1'b1;
  assign o_fail      = r_fail;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0) | (MAX_RETRIES == 0);
  assign o_fail       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_pll_reset <= 1'b1;
      r_dom       <= '0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
`ifdef PLLSEQ_TIMEOUT_EN
      r_fail      <= 1'b0;
      r_retry     <= '0;
`endif
    end else begin
      r_lock_lost <= 1'b0;
      // restart outranks every other event, including lock loss
      if (i_restart) begin
        r_state     <= ST_HOLD;
        r_cnt       <= '0;
        r_pll_reset <= 1'b1;
        r_dom       <= '0;
        r_ready     <= 1'b0;
`ifdef PLLSEQ_TIMEOUT_EN
        r_fail      <= 1'b0;
        r_retry     <= '0;
`endif
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_cnt == c_HOLD_LAST) begin
              r_state     <= ST_WAIT_LOCK;
              r_cnt       <= '0;
              r_pll_reset <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (w_lock_s) begin
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end
`ifdef PLLSEQ_TIMEOUT_EN
            else if (r_cnt == c_TO_LAST) begin
              r_retry     <= w_retry_nxt;
              r_cnt       <= '0;
              r_pll_reset <= 1'b1;
              if (w_retry_nxt < c_RTY_W'(MAX_RETRIES)) begin
                r_state <= ST_HOLD;
              end else begin
                r_state <= ST_FAIL;
                r_fail  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
`endif
          end
          ST_STABLE: begin
            if (!w_lock_s) begin
              r_state <= ST_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == c_STABLE_LAST) begin
              r_state <= ST_RELEASE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (!w_lock_s) begin
              r_state     <= ST_HOLD;
              r_cnt       <= '0;
              r_pll_reset <= 1'b1;
              r_dom       <= '0;
            end else begin
              for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (r_cnt == c_CNT_W'(i * STAGGER_CYCLES)) r_dom[i] <= 1'b1;
              end
              if (r_cnt == c_RELEASE_END) begin
                r_state <= ST_RUN;
                r_cnt   <= '0;
`ifdef PLLSEQ_TIMEOUT_EN
                r_retry <= '0;
`endif
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (!w_lock_s) begin
              r_state     <= ST_HOLD;
              r_cnt       <= '0;
              r_pll_reset <= 1'b1;
              r_dom       <= '0;
              r_ready     <= 1'b0;
              r_lock_lost <= 1'b1;
            end else begin
              r_ready <= 1'b1;
            end
          end
`ifdef PLLSEQ_TIMEOUT_EN
          ST_FAIL: begin
            r_pll_reset <= 1'b1;
          end
`endif
          default: begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_dom       <= '0;
            r_ready     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_pll_reset    = r_pll_reset;
  assign o_domain_rst_n = r_dom;
  assign o_ready        = r_ready;
  assign o_lock_lost    = r_lock_lost;
  assign o_state        = r_state;

endmodule

`default_nettype wire
